// File: rtl/voting_out_pool_pkg.sv
// rtl/voting_out_pool_pkg.sv - shared types, sizing helpers and requantisation for the conv output pooler
//
// Purpose: package voting_pkg; FSM state type, pool/index sizing helpers,
//          ReLU + arithmetic-shift requantiser with saturation.
// Ports:   none (package).
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working width for requantisation; wide enough for any DATA_W < 64.
    localparam int CALC_W = 64;

    function automatic int pool_size(input int out_size);
        return out_size / 2;
    endfunction

    function automatic int index_width(input int out_size);
        int p;
        p = out_size / 2;
        return $clog2(p * p) + 1;
    endfunction

    // ReLU, then arithmetic right shift, then clamp to the largest positive OUT_W value.
    function automatic logic signed [CALC_W-1:0] relu_requant(
        input logic signed [CALC_W-1:0] d,
        input int                       shift,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] q;
        logic signed [CALC_W-1:0] qmax;
        r    = (d < 0) ? '0 : d;
        q    = r >>> shift;
        qmax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        return (q > qmax) ? qmax : q;
    endfunction

endpackage

// File: rtl/voting_out_pool_if.sv
// rtl/voting_out_pool_if.sv - stream interface between conv top, pooler and next layer
//
// Purpose: bundles the pooler's control, input beat and pooled output signals.
// Ports:   i_start/i_en/i_data/i_done driven by master; o_en/o_data/o_index/o_done/o_err by slave.
interface voting_out_pool_if #(
    parameter int DATA_W = 48,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 3
);
    logic                     i_start;
    logic                     i_en;
    logic signed [DATA_W-1:0] i_data;
    logic                     i_done;
    logic                     o_en;
    logic signed [OUT_W-1:0]  o_data;
    logic [IDX_W-1:0]         o_index;
    logic                     o_done;
    logic                     o_err;

    modport master (
        output i_start, i_en, i_data, i_done,
        input  o_en, o_data, o_index, o_done, o_err
    );

    modport slave (
        input  i_start, i_en, i_data, i_done,
        output o_en, o_data, o_index, o_done, o_err
    );
endinterface

// File: rtl/voting_out_pool_linebuf.sv
// rtl/voting_out_pool_linebuf.sv - half-row line buffer holding even-row pair maxima
//
// Purpose: DEPTH x W register array, one write port, one combinational read port.
// Ports:   i_clk, i_rst (async high), i_clr (sync clear), i_we/i_waddr/i_wdata, i_raddr -> o_rdata.
module voting_pool_linebuf #(
    parameter int DEPTH = 2,
    parameter int W     = 16,
    parameter int AW    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/voting_out_pool.sv
// rtl/voting_out_pool.sv - ReLU/requantise then 2x2 stride-2 max-pool of the conv output stream
//
// Purpose: consumes OUT_SIZE x OUT_SIZE row-major conv results, emits pooled indexed results.
// Ports:   i_clk, i_rst (async high), bus (slave modport: i_start, i_en, i_data, i_done,
//          o_en, o_data, o_index, o_done, o_err).
module voting_out_pool
    import voting_pkg::*;
#(
    parameter int OUT_SIZE = 4,
    parameter int DATA_W   = 48,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    voting_out_pool_if.slave  bus
);
    localparam int POOL_SIZE = pool_size(OUT_SIZE);
    localparam int IDX_W     = index_width(OUT_SIZE);
    localparam int CW        = $clog2(OUT_SIZE) + 1;
    localparam int AW        = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int LIM       = 2 * POOL_SIZE;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    r_row;
    logic [OUT_W-1:0] r_pair;
    logic [IDX_W-1:0] r_idx;
    logic             r_en;
    logic [OUT_W-1:0] r_data;
    logic [IDX_W-1:0] r_index;
    logic             r_done;
    logic             r_err;

    logic             w_beat;
    logic             w_last;
    logic             w_short;
    logic             w_inwin;
    logic             w_emit;
    logic             w_lb_we;
    logic [AW-1:0]    w_addr;
    logic [OUT_W-1:0] w_q;
    logic [OUT_W-1:0] w_lb_rd;
    logic [OUT_W-1:0] w_pq;
    logic [OUT_W-1:0] w_m1;
    logic [OUT_W-1:0] w_res;

    // i_start wins over a same-cycle beat, so the beat is dropped.
    assign w_beat  = (r_state == RUN) && bus.i_en && !bus.i_start;
    assign w_last  = w_beat && (r_row == CW'(OUT_SIZE - 1)) && (r_col == CW'(OUT_SIZE - 1));
    assign w_short = (r_state == RUN) && bus.i_done && !bus.i_start && !w_last;
    // Odd trailing row/column are counted but never enter a window.
    assign w_inwin = (r_row < CW'(LIM)) && (r_col < CW'(LIM));
    assign w_emit  = w_beat && w_inwin && r_row[0] && r_col[0];
    assign w_lb_we = w_beat && w_inwin && !r_row[0] && r_col[0];
    assign w_addr  = AW'(r_col >> 1);

    // Result is non-negative and below 2^(OUT_W-1), so unsigned compares are safe.
    assign w_q   = OUT_W'(relu_requant(CALC_W'($signed(bus.i_data)), SHIFT, OUT_W));
    assign w_pq  = (r_pair > w_q) ? r_pair : w_q;
    assign w_m1  = (w_lb_rd > r_pair) ? w_lb_rd : r_pair;
    assign w_res = (w_m1 > w_q) ? w_m1 : w_q;

    voting_pool_linebuf #(
        .DEPTH (POOL_SIZE),
        .W     (OUT_W),
        .AW    (AW)
    ) u_linebuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (bus.i_start),
        .i_we    (w_lb_we),
        .i_waddr (w_addr),
        .i_wdata (w_pq),
        .i_raddr (w_addr),
        .o_rdata (w_lb_rd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_next = RUN;
            RUN:     if (bus.i_start) w_next = RUN;
                     else if (w_last || w_short) w_next = DONE;
            DONE:    if (bus.i_start) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_pair  <= '0;
            r_idx   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.i_start) begin
            r_col   <= '0;
            r_row   <= '0;
            r_pair  <= '0;
            r_idx   <= '0;
            r_en    <= 1'b0;
            r_index <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_en <= w_emit;
            if (w_beat) begin
                if (r_col == CW'(OUT_SIZE - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_inwin && !r_col[0]) r_pair <= w_q;
            end
            if (w_emit) begin
                r_data  <= w_res;
                r_index <= r_idx;
                r_idx   <= r_idx + 1'b1;
            end
            // When the finishing beat also emits, done trails that o_en by one cycle.
            r_done <= (r_state == DONE) || ((w_last || w_short) && !w_emit);
            if (w_short || ((r_state == DONE) && bus.i_en)) r_err <= 1'b1;
        end
    end

    assign bus.o_en    = r_en;
    assign bus.o_data  = r_data;
    assign bus.o_index = r_index;
    assign bus.o_done  = r_done;
    assign bus.o_err   = r_err;
endmodule
